// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and flag types shared by the pipelined ALU
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_LSL      = 3'b001,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110,
    ALU_LSR      = 3'b111
  } alu_op_t;

  // Packed so that a cast to logic [3:0] yields {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU producing result and NZCV flags
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int SHW = $clog2(WIDTH);

  alu_op_t          opc;
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic             carry_into_msb;

  assign opc = alu_op_t'(op);

  always_comb begin
    is_sub = (opc == ALU_SUBTRACT);
    b_eff  = is_sub ? ~b : b;
    // Subtract reuses the adder as A + ~B + 1
    sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt  = b[SHW-1:0];
    carry_into_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1];

    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (opc)
      ALU_PASS_B: result = b;
      ALU_LSL:    result = a << shamt;
      ALU_ADD, ALU_SUBTRACT: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = carry_into_msb ^ sum[WIDTH];
      end
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_LSR:    result = a >> shamt;
      default:    result = '0;
    endcase

    n = result[WIDTH-1];
    z = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU pipeline with valid/ready handshake and flag register
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic [3:0]       flags_q
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_sf;
  logic             s2_sf;
  logic             s1_advance;
  alu_flags_t       s2_flags;

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .n      (core_flags.n),
    .z      (core_flags.z),
    .c      (core_flags.c),
    .v      (core_flags.v)
  );

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !reset && (!s1_valid || s1_advance);

  assign negative  = s2_flags.n;
  assign zero      = s2_flags.z;
  assign carry_out = s2_flags.c;
  assign overflow  = s2_flags.v;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s1_sf     <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      s2_flags  <= '0;
      s2_sf     <= 1'b0;
      flags_q   <= '0;
    end else begin
      // Flag register commits on the retiring operation, before stage 2 is overwritten
      if (out_valid && out_ready && s2_sf) begin
        flags_q <= s2_flags;
      end
      if (s1_advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          result   <= core_result;
          s2_flags <= core_flags;
          s2_sf    <= s1_sf;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= A;
          s1_b  <= B;
          s1_op <= cntrl;
          s1_sf <= set_flags;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed vector bench for alu_pipe at WIDTH=64 and WIDTH=8
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, set_flags, out_valid, out_ready;
  logic [63:0] a, b, result;
  logic [2:0]  cntrl;
  logic        negative, zero, overflow, carry_out;
  logic [3:0]  flags_q;

  logic        in_valid8, in_ready8, set_flags8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic [2:0]  cntrl8;
  logic        negative8, zero8, overflow8, carry_out8;
  logic [3:0]  flags_q8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cntrl(cntrl), .set_flags(set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .flags_q(flags_q)
  );

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .cntrl(cntrl8), .set_flags(set_flags8),
    .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
    .negative(negative8), .zero(zero8), .overflow(overflow8), .carry_out(carry_out8),
    .flags_q(flags_q8)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        sf;
    logic [63:0] exp_res;
    logic [3:0]  exp_nzcv;
    logic [3:0]  exp_fq;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"add_ovf",   3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001, 4'b0000};
    vecs[1]  = '{"sub_eq",    3'b011, 64'h5, 64'h5, 1'b1, 64'h0, 4'b0110, 4'b0110};
    vecs[2]  = '{"sub_borrow",3'b011, 64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 4'b0110};
    vecs[3]  = '{"lsl_63",    3'b001, 64'h1, 64'd63, 1'b0, 64'h8000_0000_0000_0000, 4'b1000, 4'b0110};
    vecs[4]  = '{"lsr_64",    3'b111, 64'hF0, 64'd64, 1'b0, 64'hF0, 4'b0000, 4'b0110};
    vecs[5]  = '{"pass_b",    3'b000, 64'h123, 64'h0, 1'b1, 64'h0, 4'b0100, 4'b0100};
    vecs[6]  = '{"and",       3'b100, 64'hF0F0, 64'hFF00, 1'b1, 64'hF000, 4'b0000, 4'b0000};
    vecs[7]  = '{"or",        3'b101, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h8000_0000_0000_0001, 4'b1000, 4'b1000};
    vecs[8]  = '{"xor",       3'b110, 64'hA5, 64'hFF, 1'b0, 64'h5A, 4'b0000, 4'b1000};
    vecs[9]  = '{"add_carry", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 64'h0, 4'b0110, 4'b0110};
    vecs[10] = '{"sub_ovf",   3'b011, 64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 4'b0011};
    vecs[11] = '{"lsl_wrap",  3'b001, 64'hF, 64'h41, 1'b0, 64'h1E, 4'b0000, 4'b0011};

    reset = 1'b1;
    in_valid = 0; a = '0; b = '0; cntrl = '0; set_flags = 0; out_ready = 1;
    in_valid8 = 0; a8 = '0; b8 = '0; cntrl8 = '0; set_flags8 = 0; out_ready8 = 1;
    tick();
    tick();
    check("reset_in_ready", 64'(in_ready), 64'h0);
    reset = 1'b0;
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'h1);
    check("reset_out_valid", 64'(out_valid), 64'h0);
    check("reset_result", result, 64'h0);
    check("reset_flags", 64'({negative, zero, carry_out, overflow}), 64'h0);
    check("reset_flags_q", 64'(flags_q), 64'h0);

    // One operation at a time: exact two-cycle latency, result, flags, then flag register
    for (int i = 0; i < 12; i++) begin
      in_valid = 1; cntrl = vecs[i].op; a = vecs[i].a; b = vecs[i].b; set_flags = vecs[i].sf;
      tick();
      in_valid = 0;
      check({vecs[i].name, "_lat1"}, 64'(out_valid), 64'h0);
      tick();
      check({vecs[i].name, "_lat2"}, 64'(out_valid), 64'h1);
      check({vecs[i].name, "_res"}, result, vecs[i].exp_res);
      check({vecs[i].name, "_nzcv"}, 64'({negative, zero, carry_out, overflow}), 64'(vecs[i].exp_nzcv));
      tick();
      check({vecs[i].name, "_fq"}, 64'(flags_q), 64'(vecs[i].exp_fq));
      check({vecs[i].name, "_drain"}, 64'(out_valid), 64'h0);
    end

    // Narrow instance: 8-bit carry wrap and xor
    in_valid8 = 1; cntrl8 = 3'b010; a8 = 8'hFF; b8 = 8'h01; set_flags8 = 1;
    tick();
    cntrl8 = 3'b110; a8 = 8'hA5; b8 = 8'hFF; set_flags8 = 0;
    tick();
    in_valid8 = 0;
    check("w8_add_valid", 64'(out_valid8), 64'h1);
    check("w8_add_res", 64'(result8), 64'h0);
    check("w8_add_nzcv", 64'({negative8, zero8, carry_out8, overflow8}), 64'b0110);
    tick();
    check("w8_xor_valid", 64'(out_valid8), 64'h1);
    check("w8_xor_res", 64'(result8), 64'h5A);
    check("w8_fq", 64'(flags_q8), 64'b0110);

    // Backpressure: four ADDs (i + 100) offered against a stalled output
    begin
      int idx = 0;
      int nret = 0;
      int first_cyc = -1;
      int last_cyc = -1;
      logic hs, ret;
      logic [63:0] rres;
      logic [63:0] got[$];
      out_ready = 0;
      set_flags = 0;
      cntrl = 3'b010;
      for (int c = 0; c < 4; c++) begin
        in_valid = 1; a = 64'(idx); b = 64'd100;
        hs = in_ready;
        tick();
        if (hs) idx++;
      end
      check("bp_accepted", 64'(idx), 64'd2);
      check("bp_in_ready_low", 64'(in_ready), 64'h0);
      for (int c = 0; c < 2; c++) begin
        check("bp_hold_valid", 64'(out_valid), 64'h1);
        check("bp_hold_res", result, 64'd100);
        a = 64'hDEAD; b = 64'hBEEF;
        tick();
      end
      out_ready = 1;
      #1;
      for (int c = 0; c < 20 && nret < 4; c++) begin
        in_valid = (idx < 4);
        a = 64'(idx); b = 64'd100;
        hs = in_valid && in_ready;
        ret = out_valid;
        rres = result;
        tick();
        if (hs) idx++;
        if (ret) begin
          got.push_back(rres);
          if (first_cyc < 0) first_cyc = c;
          last_cyc = c;
          nret++;
        end
      end
      in_valid = 0;
      check("bp_retired", 64'(nret), 64'd4);
      check("bp_back_to_back", 64'(last_cyc - first_cyc), 64'd3);
      for (int k = 0; k < 4; k++) begin
        check("bp_order", (k < got.size()) ? got[k] : 64'hX, 64'(100 + k));
      end
    end

    // Reset with both stages full of flag-setting SUB 5-5 ops
    tick();
    out_ready = 0;
    in_valid = 1; cntrl = 3'b011; a = 64'h5; b = 64'h5; set_flags = 1;
    tick();
    tick();
    in_valid = 0;
    check("rst_full", 64'({out_valid, in_ready}), 64'b10);
    reset = 1;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_flags_q", 64'(flags_q), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h0);
    reset = 0;
    out_ready = 1;
    #1;
    check("rst_release_ready", 64'(in_ready), 64'h1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_no_retire", 64'({out_valid, flags_q}), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
